// File: rtl/subexpr_seq_engine_if.sv
// -----------------------------------------------------------------------------
// subexpr_seq_engine_if
// Bundles the operand/result handshake of subexpr_seq_engine.
//   start          : run request from the operand source
//   A..H           : operands, sampled by the engine on the accepting edge
//   busy           : engine is executing a run
//   done           : one-cycle pulse after the results were committed
//   result1..6     : registered results of the last completed run
// Modports:
//   master : operand source / result consumer side
//   slave  : engine side
// -----------------------------------------------------------------------------
interface subexpr_seq_engine_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] E;
    logic [WIDTH-1:0] F;
    logic [WIDTH-1:0] G;
    logic [WIDTH-1:0] H;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result1;
    logic [WIDTH-1:0] result2;
    logic [WIDTH-1:0] result3;
    logic [WIDTH-1:0] result4;
    logic [WIDTH-1:0] result5;
    logic [WIDTH-1:0] result6;

    modport master (
        output start, A, B, C, D, E, F, G, H,
        input  busy, done, result1, result2, result3, result4, result5, result6
    );

    modport slave (
        input  start, A, B, C, D, E, F, G, H,
        output busy, done, result1, result2, result3, result4, result5, result6
    );
endinterface

// File: rtl/subexpr_seq_engine.sv
// -----------------------------------------------------------------------------
// subexpr_seq_engine
// Multi-cycle sequencer computing the six shared-subexpression results
//   r1=s+p  r2=p+d  r3=(s+G)+H  r4=(p+E)*s  r5=(p+B)-(F+s)  r6=(s+C)*d
//   with s=A+B, p=C*D, d=E-F
// using one shared add/sub unit and one shared multiplier over a fixed
// 14-step micro-op schedule. All six results are committed together.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : subexpr_seq_engine_if.slave (start, A..H, busy, done, result1..6)
//
// Build option:
//   SUBEXPR_MUL_PIPE_EN : registers the multiplier inputs; every multiply
//                         step spends one extra cycle in MWAIT (latency 17
//                         instead of 14). Results are identical.
// -----------------------------------------------------------------------------
module subexpr_seq_engine #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    subexpr_seq_engine_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        MWAIT = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    localparam logic [3:0] LAST_STEP = 4'd13;

    // Temp slot n is written by step n, so the step counter doubles as the
    // write address. Named slots used as sources or committed results:
    localparam int T_S  = 0;   // s  = A+B
    localparam int T_P  = 1;   // p  = C*D
    localparam int T_D  = 2;   // d  = E-F
    localparam int T_R1 = 3;
    localparam int T_R2 = 4;
    localparam int T_T  = 5;   // t  = s+G
    localparam int T_R3 = 6;
    localparam int T_U  = 7;   // u  = p+E
    localparam int T_R4 = 8;
    localparam int T_V  = 9;   // v  = p+B
    localparam int T_W  = 10;  // w  = F+s
    localparam int T_R5 = 11;
    localparam int T_X  = 12;  // x  = s+C

    state_t           state_r;
    state_t           state_n;
    logic [3:0]       step_r;
    logic             busy_r;
    logic             done_r;

    logic [WIDTH-1:0] a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r;
    logic [WIDTH-1:0] tmp_r [0:15];
    logic [WIDTH-1:0] result_r [0:5];

    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] op_b_s;
    logic [1:0]       op_kind_s;
    logic [WIDTH-1:0] alu_s;
    logic [WIDTH-1:0] mul_s;
    logic [WIDTH-1:0] wr_val_s;
    logic             is_mul_s;
    logic             last_s;

    logic             accept_s;
    logic             wr_en_s;
    logic             step_inc_s;
    logic             commit_s;
    logic             mul_load_s;

    // Micro-op schedule: operand selection and operation for the current step.
    always_comb begin
        op_a_s    = '0;
        op_b_s    = '0;
        op_kind_s = OP_ADD;
        case (step_r)
            4'd0:    begin op_a_s = a_r;         op_b_s = b_r;         op_kind_s = OP_ADD; end
            4'd1:    begin op_a_s = c_r;         op_b_s = d_r;         op_kind_s = OP_MUL; end
            4'd2:    begin op_a_s = e_r;         op_b_s = f_r;         op_kind_s = OP_SUB; end
            4'd3:    begin op_a_s = tmp_r[T_S];  op_b_s = tmp_r[T_P];  op_kind_s = OP_ADD; end
            4'd4:    begin op_a_s = tmp_r[T_P];  op_b_s = tmp_r[T_D];  op_kind_s = OP_ADD; end
            4'd5:    begin op_a_s = tmp_r[T_S];  op_b_s = g_r;         op_kind_s = OP_ADD; end
            4'd6:    begin op_a_s = tmp_r[T_T];  op_b_s = h_r;         op_kind_s = OP_ADD; end
            4'd7:    begin op_a_s = tmp_r[T_P];  op_b_s = e_r;         op_kind_s = OP_ADD; end
            4'd8:    begin op_a_s = tmp_r[T_U];  op_b_s = tmp_r[T_S];  op_kind_s = OP_MUL; end
            4'd9:    begin op_a_s = tmp_r[T_P];  op_b_s = b_r;         op_kind_s = OP_ADD; end
            4'd10:   begin op_a_s = f_r;         op_b_s = tmp_r[T_S];  op_kind_s = OP_ADD; end
            4'd11:   begin op_a_s = tmp_r[T_V];  op_b_s = tmp_r[T_W];  op_kind_s = OP_SUB; end
            4'd12:   begin op_a_s = tmp_r[T_S];  op_b_s = c_r;         op_kind_s = OP_ADD; end
            4'd13:   begin op_a_s = tmp_r[T_X];  op_b_s = tmp_r[T_D];  op_kind_s = OP_MUL; end
            default: begin op_a_s = '0;          op_b_s = '0;          op_kind_s = OP_ADD; end
        endcase
    end

    assign is_mul_s = (op_kind_s == OP_MUL);
    assign last_s   = (step_r == LAST_STEP);
    assign alu_s    = (op_kind_s == OP_SUB) ? (op_a_s - op_b_s) : (op_a_s + op_b_s);

`ifdef SUBEXPR_MUL_PIPE_EN
    logic [WIDTH-1:0] mul_a_r;
    logic [WIDTH-1:0] mul_b_r;

    // Multiplier input stage, loaded in the EXEC cycle of a multiply step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_r <= '0;
            mul_b_r <= '0;
        end else if (mul_load_s) begin
            mul_a_r <= op_a_s;
            mul_b_r <= op_b_s;
        end
    end

    assign mul_s = mul_a_r * mul_b_r;
`else
    assign mul_s = op_a_s * op_b_s;
`endif

    assign wr_val_s = is_mul_s ? mul_s : alu_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_n    = state_r;
        accept_s   = 1'b0;
        wr_en_s    = 1'b0;
        step_inc_s = 1'b0;
        commit_s   = 1'b0;
        mul_load_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    accept_s = 1'b1;
                    state_n  = EXEC;
                end else begin
                    state_n  = IDLE;
                end
            end
            EXEC: begin
`ifdef SUBEXPR_MUL_PIPE_EN
                if (is_mul_s) begin
                    mul_load_s = 1'b1;
                    state_n    = MWAIT;
                end else begin
                    wr_en_s = 1'b1;
                    if (last_s) begin
                        commit_s = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        step_inc_s = 1'b1;
                        state_n    = EXEC;
                    end
                end
`else
                wr_en_s = 1'b1;
                if (last_s) begin
                    commit_s = 1'b1;
                    state_n  = IDLE;
                end else begin
                    step_inc_s = 1'b1;
                    state_n    = EXEC;
                end
`endif
            end
            MWAIT: begin
`ifdef SUBEXPR_MUL_PIPE_EN
                wr_en_s = 1'b1;
                if (last_s) begin
                    commit_s = 1'b1;
                    state_n  = IDLE;
                end else begin
                    step_inc_s = 1'b1;
                    state_n    = EXEC;
                end
`else
                // Not reachable without the multiplier input stage.
                state_n = IDLE;
`endif
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Operand capture, temp file, step counter, status and result commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_r <= 4'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            c_r    <= '0;
            d_r    <= '0;
            e_r    <= '0;
            f_r    <= '0;
            g_r    <= '0;
            h_r    <= '0;
            for (int i = 0; i < 16; i++) begin
                tmp_r[i] <= '0;
            end
            for (int i = 0; i < 6; i++) begin
                result_r[i] <= '0;
            end
        end else begin
            done_r <= commit_s;
            if (accept_s) begin
                a_r    <= bus.A;
                b_r    <= bus.B;
                c_r    <= bus.C;
                d_r    <= bus.D;
                e_r    <= bus.E;
                f_r    <= bus.F;
                g_r    <= bus.G;
                h_r    <= bus.H;
                step_r <= 4'd0;
                busy_r <= 1'b1;
            end
            if (wr_en_s) begin
                tmp_r[step_r] <= wr_val_s;
            end
            if (step_inc_s) begin
                step_r <= step_r + 4'd1;
            end
            if (commit_s) begin
                // r6 is produced by this very step, so take it straight
                // from the datapath rather than from the temp file.
                result_r[0] <= tmp_r[T_R1];
                result_r[1] <= tmp_r[T_R2];
                result_r[2] <= tmp_r[T_R3];
                result_r[3] <= tmp_r[T_R4];
                result_r[4] <= tmp_r[T_R5];
                result_r[5] <= wr_val_s;
                step_r      <= 4'd0;
                busy_r      <= 1'b0;
            end
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.result1 = result_r[0];
    assign bus.result2 = result_r[1];
    assign bus.result3 = result_r[2];
    assign bus.result4 = result_r[3];
    assign bus.result5 = result_r[4];
    assign bus.result6 = result_r[5];

endmodule

// File: tb/tb_subexpr_seq_engine.sv
// -----------------------------------------------------------------------------
// tb_subexpr_seq_engine
// Scoreboard bench: each issued run pushes its expected results and completion
// cycle; a monitor process pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_subexpr_seq_engine;

    localparam int WIDTH = 32;
`ifdef SUBEXPR_MUL_PIPE_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 14;
`endif

    logic clk = 1'b0;
    logic rst;

    subexpr_seq_engine_if #(.WIDTH(WIDTH)) bus ();

    subexpr_seq_engine #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [5:0][31:0] r;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    int               tests = 0;
    int               fails = 0;
    logic [31:0]      ops  [3][8];
    logic [5:0][31:0] expv [3];

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [191:0] act, input logic [191:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0][31:0] get_results();
        logic [5:0][31:0] r;
        r[0] = bus.result1;
        r[1] = bus.result2;
        r[2] = bus.result3;
        r[3] = bus.result4;
        r[4] = bus.result5;
        r[5] = bus.result6;
        return r;
    endfunction

    task automatic set_ops(input int idx);
        bus.A = ops[idx][0];
        bus.B = ops[idx][1];
        bus.C = ops[idx][2];
        bus.D = ops[idx][3];
        bus.E = ops[idx][4];
        bus.F = ops[idx][5];
        bus.G = ops[idx][6];
        bus.H = ops[idx][7];
    endtask

    task automatic push(input int idx, input int done_cyc);
        exp_t e;
        e.r   = expv[idx];
        e.cyc = done_cyc;
        sb.push_back(e);
    endtask

    // Waits (bounded) for done; counts busy cycles seen before it.
    task automatic wait_done(input string name, input bit drop_start, output int busy_cnt);
        bit seen;
        seen     = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (i == 0 && drop_start) bus.start = 1'b0;
            if (bus.done) seen = 1'b1;
            else if (bus.busy) busy_cnt++;
        end
        check_int({name, "_done_seen"}, int'(seen), 1);
    endtask

    int bc;
    int base;
    int bad;

    initial begin
        // Vector 0: basic
        ops[0] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd10, 32'd5, 32'd7, 32'd8};
        expv[0] = {32'd30, 32'd6, 32'd66, 32'd18, 32'd17, 32'd15};
        // Vector 1: wrap-around
        ops[1] = '{32'hFFFF_FFFF, 32'd1, 32'h0001_0000, 32'h0001_0000,
                   32'd0, 32'd1, 32'd0, 32'd0};
        expv[1] = {32'hFFFF_0000, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
        // Vector 2: s=11 p=56 d=-1
        ops[2] = '{32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12};
        expv[2] = {32'hFFFF_FFEE, 32'd41, 32'd715, 32'd34, 32'd55, 32'd67};

        rst       = 1'b1;
        bus.start = 1'b0;
        set_ops(0);

        fork
            // Monitor: every done pulse must match the oldest expected run.
            forever begin
                @(negedge clk);
                if (!rst && bus.done) begin
                    check_int("done_expected", int'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        exp_t e;
                        logic [5:0][31:0] act;
                        e   = sb.pop_front();
                        act = get_results();
                        for (int k = 0; k < 6; k++) begin
                            check_vec($sformatf("result%0d", k + 1),
                                      192'(act[k]), 192'(e.r[k]));
                        end
                        check_int("done_cycle", cyc, e.cyc);
                    end
                end
            end
        join_none

        // Reset state, sampled mid-cycle while rst is held.
        #12;
        check_int("rst_busy", int'(bus.busy), 0);
        check_int("rst_done", int'(bus.done), 0);
        check_vec("rst_results", 192'(get_results()), 192'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic run.
        set_ops(0);
        bus.start = 1'b1;
        push(0, cyc + 1 + LAT);
        wait_done("basic", 1'b1, bc);
        check_int("basic_busy_cycles", bc, LAT);
        @(negedge clk);
        check_int("done_single_pulse", int'(bus.done), 0);

        // Wrap run.
        set_ops(1);
        bus.start = 1'b1;
        push(1, cyc + 1 + LAT);
        wait_done("wrap", 1'b1, bc);
        check_int("wrap_busy_cycles", bc, LAT);
        repeat (2) @(negedge clk);

        // Busy lockout: start held, operands changed at E3, re-accept in done cycle.
        set_ops(0);
        bus.start = 1'b1;
        base = cyc + 1;
        push(0, base + LAT);
        repeat (4) @(posedge clk);
        #1;
        set_ops(1);
        push(1, base + 2 * LAT + 1);
        wait_done("lock_first", 1'b0, bc);
        wait_done("lock_second", 1'b1, bc);
        check_int("lock_second_busy_cycles", bc, LAT);
        repeat (2) @(negedge clk);

        // Reset mid-run at E7: outputs clear immediately, no done follows.
        set_ops(2);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_int("midrst_busy", int'(bus.busy), 0);
        check_int("midrst_done", int'(bus.done), 0);
        check_vec("midrst_results", 192'(get_results()), 192'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Fresh run after the abort.
        set_ops(2);
        bus.start = 1'b1;
        push(2, cyc + 1 + LAT);
        wait_done("after_rst", 1'b1, bc);
        check_int("after_rst_busy_cycles", bc, LAT);

        // Hold: idle for 20 cycles, results must stay put.
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.busy || bus.done) bad++;
        end
        check_int("hold_idle_cycles_active", bad, 0);
        check_vec("hold_results", 192'(get_results()), 192'(expv[2]));

        check_int("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
